// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared codes, state encoding and widths for the ysyx_22041211 load/store unit.
// Decoder load/store codes match the core's ysyx_22041211_define.v values.
package ysyx_22041211_lsu_pkg;

  localparam int DATA_LEN = 32;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LH   = 3'd2;
  localparam logic [2:0] LOAD_LW   = 3'd3;
  localparam logic [2:0] LOAD_LBU  = 3'd4;
  localparam logic [2:0] LOAD_LHU  = 3'd5;

  localparam logic [1:0] STORE_NONE = 2'd0;
  localparam logic [1:0] STORE_SB   = 2'd1;
  localparam logic [1:0] STORE_SH   = 2'd2;
  localparam logic [1:0] STORE_SW   = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_OUT  = 2'd3
  } lsu_state_e;

  // A load code wins over a store code when both are set.
  function automatic logic is_misaligned(logic [2:0] load_type, logic [1:0] store_type,
                                         logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (load_type != LOAD_NONE) begin
      if (load_type == LOAD_LH || load_type == LOAD_LHU) bad = off[0];
      else if (load_type == LOAD_LW)                     bad = (off != 2'b00);
    end else begin
      if (store_type == STORE_SH)      bad = off[0];
      else if (store_type == STORE_SW) bad = (off != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_if.sv
// Pipeline (EXU in / WB out) and data-memory bus bundles for the LSU.
// In each, the slave/master modport named for the LSU side is what the top uses.
interface ysyx_22041211_lsu_if;
  import ysyx_22041211_lsu_pkg::*;

  logic                exu_valid_i;
  logic                lsu_ready_o;
  logic                wd_i;
  logic [4:0]          wreg_i;
  logic [DATA_LEN-1:0] alu_result_i;
  logic [DATA_LEN-1:0] store_data_i;
  logic [2:0]          load_type_i;
  logic [1:0]          store_type_i;
  logic                wb_valid_o;
  logic                wb_ready_i;
  logic                wd_o;
  logic [4:0]          wreg_o;
  logic [DATA_LEN-1:0] wdata_o;
  logic                misalign_o;

  modport slave (
    input  exu_valid_i, wd_i, wreg_i, alu_result_i, store_data_i, load_type_i,
           store_type_i, wb_ready_i,
    output lsu_ready_o, wb_valid_o, wd_o, wreg_o, wdata_o, misalign_o
  );

  modport master (
    output exu_valid_i, wd_i, wreg_i, alu_result_i, store_data_i, load_type_i,
           store_type_i, wb_ready_i,
    input  lsu_ready_o, wb_valid_o, wd_o, wreg_o, wdata_o, misalign_o
  );
endinterface

interface ysyx_22041211_lsu_mem_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/ysyx_22041211_lsu_align.sv
// Byte-lane logic: store strobe/replication, load extraction/extension, misalignment.
// Misalignment detection exists only with YSYX_22041211_LSU_MISALIGN_CHK_EN defined.
module ysyx_22041211_lsu_align
  import ysyx_22041211_lsu_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [2:0]  rd_type,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    wmask = 4'b0000;
    wdata = 32'h0;
    if (load_type == LOAD_NONE) begin
      case (store_type)
        STORE_SB: begin
          wmask = 4'b0001 << off;
          wdata = {4{store_data[7:0]}};
        end
        STORE_SH: begin
          wmask = 4'b0011 << {off[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        STORE_SW: begin
          wmask = 4'hF;
          wdata = store_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (rd_off)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
    rd_half = rd_off[1] ? rdata[31:16] : rdata[15:0];
    case (rd_type)
      LOAD_LB:  load_data = {{24{rd_byte[7]}}, rd_byte};
      LOAD_LBU: load_data = {24'h0, rd_byte};
      LOAD_LH:  load_data = {{16{rd_half[15]}}, rd_half};
      LOAD_LHU: load_data = {16'h0, rd_half};
      default:  load_data = rdata;
    endcase
  end

`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
  assign misalign = is_misaligned(load_type, store_type, off);
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// LSU top: accepts one EXU instruction, runs the memory transaction, hands WB a final result.
// Option: YSYX_22041211_LSU_MISALIGN_CHK_EN short-circuits misaligned accesses to OUT.
//
// state | meaning
// IDLE  | ready for a new instruction from EXU
// REQ   | bus request asserted, fields held until grant
// WAIT  | granted, waiting for the response
// OUT   | result presented to WB until accepted
module ysyx_22041211_lsu
  import ysyx_22041211_lsu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  ysyx_22041211_lsu_if.slave      pipe,
  ysyx_22041211_lsu_mem_if.master mem
);

  lsu_state_e state, next_state;

  logic        ready_q;
  logic        wd_q;
  logic [4:0]  wreg_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  load_type_q;
  logic        we_q;
  logic [3:0]  wmask_q;
  logic [31:0] mem_wdata_q;
  logic        misalign_q;

  logic        accept;
  logic        is_mem;
  logic [3:0]  wmask_d;
  logic [31:0] mem_wdata_d;
  logic [31:0] load_data;
  logic        misalign_d;

  ysyx_22041211_lsu_align u_align (
    .load_type  (pipe.load_type_i),
    .store_type (pipe.store_type_i),
    .off        (pipe.alu_result_i[1:0]),
    .store_data (pipe.store_data_i),
    .rd_type    (load_type_q),
    .rd_off     (addr_q[1:0]),
    .rdata      (mem.mem_rdata_i),
    .wmask      (wmask_d),
    .wdata      (mem_wdata_d),
    .load_data  (load_data),
    .misalign   (misalign_d)
  );

  assign is_mem = (pipe.load_type_i != LOAD_NONE) || (pipe.store_type_i != STORE_NONE);
  assign accept = (state == LSU_IDLE) && ready_q && pipe.exu_valid_i;

  always_ff @(posedge clk) begin
    if (rst) state <= LSU_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LSU_IDLE: if (accept) next_state = (is_mem && !misalign_d) ? LSU_REQ : LSU_OUT;
      LSU_REQ:  if (mem.mem_gnt_i) next_state = LSU_WAIT;
      LSU_WAIT: if (mem.mem_rvalid_i) next_state = LSU_OUT;
      LSU_OUT:  if (pipe.wb_ready_i) next_state = LSU_IDLE;
      default:  next_state = LSU_IDLE;
    endcase
  end

  // ready is registered from the next state so no input reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      wd_q        <= 1'b0;
      wreg_q      <= 5'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      load_type_q <= LOAD_NONE;
      we_q        <= 1'b0;
      wmask_q     <= 4'h0;
      mem_wdata_q <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      ready_q <= (next_state == LSU_IDLE);
      if (accept) begin
        wd_q        <= pipe.wd_i && !misalign_d;
        wreg_q      <= pipe.wreg_i;
        addr_q      <= pipe.alu_result_i;
        wdata_q     <= pipe.alu_result_i;
        load_type_q <= pipe.load_type_i;
        we_q        <= (pipe.load_type_i == LOAD_NONE) && (pipe.store_type_i != STORE_NONE);
        wmask_q     <= wmask_d;
        mem_wdata_q <= mem_wdata_d;
        misalign_q  <= misalign_d;
      end else if (state == LSU_WAIT && mem.mem_rvalid_i && load_type_q != LOAD_NONE) begin
        wdata_q <= load_data;
      end
    end
  end

  assign pipe.lsu_ready_o = ready_q;
  assign pipe.wb_valid_o  = (state == LSU_OUT);
  assign pipe.wd_o        = wd_q;
  assign pipe.wreg_o      = wreg_q;
  assign pipe.wdata_o     = wdata_q;
  assign pipe.misalign_o  = misalign_q;

  assign mem.mem_req_o   = (state == LSU_REQ);
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem.mem_wdata_o = mem_wdata_q;
  assign mem.mem_wmask_o = wmask_q;

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Directed bench for ysyx_22041211_lsu: hand-computed vectors, bus and WB driven from tasks.
module tb_ysyx_22041211_lsu;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;
  int   hs_cnt;

  ysyx_22041211_lsu_if     pipe_if ();
  ysyx_22041211_lsu_mem_if mem_if ();

  ysyx_22041211_lsu dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (pipe_if),
    .mem  (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pipe_if.wb_valid_o && pipe_if.wb_ready_i) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] ltype, input logic [1:0] stype, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic wd, input logic [4:0] wreg);
    pipe_if.exu_valid_i  = 1'b1;
    pipe_if.load_type_i  = ltype;
    pipe_if.store_type_i = stype;
    pipe_if.alu_result_i = addr;
    pipe_if.store_data_i = sdata;
    pipe_if.wd_i         = wd;
    pipe_if.wreg_i       = wreg;
    cycle();
    pipe_if.exu_valid_i  = 1'b0;
    pipe_if.alu_result_i = 32'h5A5A5A5A;
    pipe_if.store_data_i = 32'hA5A5A5A5;
  endtask

  task automatic wb_drain(input string tag, input int rdy_dly, input bit chk_data,
                          input logic [31:0] exp_wdata, input logic exp_wd,
                          input logic [4:0] exp_wreg, input logic exp_mis);
    int hs0;
    chk({tag, ".valid"}, {31'd0, pipe_if.wb_valid_o}, 32'd1);
    if (chk_data) chk({tag, ".wdata"}, pipe_if.wdata_o, exp_wdata);
    chk({tag, ".wd"}, {31'd0, pipe_if.wd_o}, {31'd0, exp_wd});
    chk({tag, ".wreg"}, {27'd0, pipe_if.wreg_o}, {27'd0, exp_wreg});
    chk({tag, ".mis"}, {31'd0, pipe_if.misalign_o}, {31'd0, exp_mis});
    hs0 = hs_cnt;
    repeat (rdy_dly) cycle();
    if (rdy_dly > 0) begin
      chk({tag, ".hold_valid"}, {31'd0, pipe_if.wb_valid_o}, 32'd1);
      chk({tag, ".hold_wreg"}, {27'd0, pipe_if.wreg_o}, {27'd0, exp_wreg});
      if (chk_data) chk({tag, ".hold_wdata"}, pipe_if.wdata_o, exp_wdata);
    end
    pipe_if.wb_ready_i = 1'b1;
    cycle();
    pipe_if.wb_ready_i = 1'b0;
    chk({tag, ".valid_drop"}, {31'd0, pipe_if.wb_valid_o}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, pipe_if.lsu_ready_o}, 32'd1);
    chk({tag, ".handshakes"}, hs_cnt - hs0, 32'd1);
  endtask

  task automatic mem_op(input string tag, input logic [2:0] ltype, input logic [1:0] stype,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic wd,
                        input logic [4:0] wreg, input int gnt_dly, input logic [31:0] rdata,
                        input int rv_dly, input int rdy_dly, input logic exp_we,
                        input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                        input logic [31:0] exp_mwdata, input logic [31:0] exp_wb,
                        input logic exp_wd);
    issue(ltype, stype, addr, sdata, wd, wreg);
    chk({tag, ".req"}, {31'd0, mem_if.mem_req_o}, 32'd1);
    chk({tag, ".busy"}, {31'd0, pipe_if.lsu_ready_o}, 32'd0);
    chk({tag, ".we"}, {31'd0, mem_if.mem_we_o}, {31'd0, exp_we});
    chk({tag, ".addr"}, mem_if.mem_addr_o, exp_addr);
    chk({tag, ".mask"}, {28'd0, mem_if.mem_wmask_o}, {28'd0, exp_mask});
    if (exp_we) chk({tag, ".mwdata"}, mem_if.mem_wdata_o, exp_mwdata);
    repeat (gnt_dly) cycle();
    if (gnt_dly > 0) begin
      chk({tag, ".hold_req"}, {31'd0, mem_if.mem_req_o}, 32'd1);
      chk({tag, ".hold_addr"}, mem_if.mem_addr_o, exp_addr);
      chk({tag, ".hold_mask"}, {28'd0, mem_if.mem_wmask_o}, {28'd0, exp_mask});
    end
    mem_if.mem_gnt_i = 1'b1;
    cycle();
    mem_if.mem_gnt_i = 1'b0;
    chk({tag, ".req_drop"}, {31'd0, mem_if.mem_req_o}, 32'd0);
    repeat (rv_dly) cycle();
    mem_if.mem_rdata_i  = rdata;
    mem_if.mem_rvalid_i = 1'b1;
    cycle();
    mem_if.mem_rvalid_i = 1'b0;
    mem_if.mem_rdata_i  = 32'h13579BDF;
    wb_drain(tag, rdy_dly, !exp_we, exp_wb, exp_wd, wreg, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"}, {31'd0, mem_if.mem_req_o}, 32'd0);
    chk({tag, ".we"}, {31'd0, mem_if.mem_we_o}, 32'd0);
    chk({tag, ".addr"}, mem_if.mem_addr_o, 32'd0);
    chk({tag, ".mwdata"}, mem_if.mem_wdata_o, 32'd0);
    chk({tag, ".mask"}, {28'd0, mem_if.mem_wmask_o}, 32'd0);
    chk({tag, ".valid"}, {31'd0, pipe_if.wb_valid_o}, 32'd0);
    chk({tag, ".wd"}, {31'd0, pipe_if.wd_o}, 32'd0);
    chk({tag, ".wreg"}, {27'd0, pipe_if.wreg_o}, 32'd0);
    chk({tag, ".wdata"}, pipe_if.wdata_o, 32'd0);
    chk({tag, ".mis"}, {31'd0, pipe_if.misalign_o}, 32'd0);
  endtask

  initial begin
    int hs0;
    vec_cnt = 0;
    err_cnt = 0;
    hs_cnt  = 0;
    rst = 1'b1;
    pipe_if.exu_valid_i  = 1'b0;
    pipe_if.wd_i         = 1'b0;
    pipe_if.wreg_i       = 5'd0;
    pipe_if.alu_result_i = 32'h0;
    pipe_if.store_data_i = 32'h0;
    pipe_if.load_type_i  = 3'd0;
    pipe_if.store_type_i = 2'd0;
    pipe_if.wb_ready_i   = 1'b0;
    mem_if.mem_gnt_i     = 1'b0;
    mem_if.mem_rvalid_i  = 1'b0;
    mem_if.mem_rdata_i   = 32'h0;
    @(negedge clk);
    cycle();
    cycle();
    chk_all_zero("rst");
    chk("rst.ready", {31'd0, pipe_if.lsu_ready_o}, 32'd0);
    rst = 1'b0;
    cycle();
    chk("rst.ready_after", {31'd0, pipe_if.lsu_ready_o}, 32'd1);

    // ALU op: one-cycle latency, no bus activity
    issue(3'd0, 2'd0, 32'h0000_1234, 32'h0, 1'b1, 5'd5);
    chk("add.noreq", {31'd0, mem_if.mem_req_o}, 32'd0);
    wb_drain("add", 0, 1'b1, 32'h0000_1234, 1'b1, 5'd5, 1'b0);

    // tag ltype stype addr sdata wd wreg gnt rdata rv rdy | we addr mask mwdata wb wd
    mem_op("sb", 3'd0, 2'd1, 32'h8000_0003, 32'h0000_00AB, 1'b0, 5'd0, 0, 32'h0, 0, 0,
           1'b1, 32'h8000_0000, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0);
    mem_op("sh", 3'd0, 2'd2, 32'h8000_0006, 32'h1234_CDEF, 1'b0, 5'd3, 1, 32'h0, 1, 0,
           1'b1, 32'h8000_0004, 4'b1100, 32'hCDEF_CDEF, 32'h0, 1'b0);
    mem_op("sw", 3'd0, 2'd3, 32'h0000_0100, 32'h1122_3344, 1'b0, 5'd0, 0, 32'h0, 0, 0,
           1'b1, 32'h0000_0100, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
    mem_op("lb", 3'd1, 2'd0, 32'h8000_0001, 32'h0, 1'b1, 5'd10, 0, 32'h0000_F000, 0, 0,
           1'b0, 32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_FFF0, 1'b1);
    mem_op("lhu", 3'd5, 2'd0, 32'h8000_0002, 32'h0, 1'b1, 5'd11, 0, 32'h8001_0000, 0, 0,
           1'b0, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_8001, 1'b1);
    mem_op("lh", 3'd2, 2'd0, 32'h8000_0000, 32'h0, 1'b1, 5'd12, 0, 32'h0000_8000, 0, 0,
           1'b0, 32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_8000, 1'b1);
    mem_op("lbu", 3'd4, 2'd0, 32'h0000_0003, 32'h0, 1'b1, 5'd13, 0, 32'h9A00_0000, 2, 0,
           1'b0, 32'h0000_0000, 4'h0, 32'h0, 32'h0000_009A, 1'b1);
    mem_op("lw_stall", 3'd3, 2'd0, 32'h8000_0010, 32'h0, 1'b1, 5'd14, 3, 32'hDEAD_BEEF, 0, 2,
           1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    mem_op("ld_over_st", 3'd3, 2'd3, 32'h0000_0020, 32'h0000_0055, 1'b1, 5'd15, 0,
           32'h0102_0304, 0, 0, 1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'h0102_0304, 1'b1);

`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
    issue(3'd3, 2'd0, 32'h8000_0002, 32'h0, 1'b1, 5'd7);
    chk("mis.noreq", {31'd0, mem_if.mem_req_o}, 32'd0);
    wb_drain("mis", 0, 1'b0, 32'h0, 1'b0, 5'd7, 1'b1);
`else
    mem_op("lw_unal", 3'd3, 2'd0, 32'h8000_0002, 32'h0, 1'b1, 5'd7, 0, 32'hCAFE_F00D, 0, 0,
           1'b0, 32'h8000_0000, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b1);
`endif

    // Reset while waiting for the response; a late rvalid must be dropped.
    issue(3'd3, 2'd0, 32'h0000_0040, 32'h0, 1'b1, 5'd9);
    mem_if.mem_gnt_i = 1'b1;
    cycle();
    mem_if.mem_gnt_i = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk_all_zero("rst_wait");
    chk("rst_wait.ready", {31'd0, pipe_if.lsu_ready_o}, 32'd0);
    hs0 = hs_cnt;
    mem_if.mem_rdata_i  = 32'hFFFF_FFFF;
    mem_if.mem_rvalid_i = 1'b1;
    pipe_if.wb_ready_i  = 1'b1;
    cycle();
    mem_if.mem_rvalid_i = 1'b0;
    chk("rst_wait.ready_after", {31'd0, pipe_if.lsu_ready_o}, 32'd1);
    repeat (3) cycle();
    pipe_if.wb_ready_i = 1'b0;
    chk_all_zero("rst_late");
    chk("rst_late.handshakes", hs_cnt - hs0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end want end");
    $fatal(1, "bench timeout");
  end

endmodule
